acquire_sequencer: RTL

//  Command-driven acquisition controller between the UART receiver, ADC sample stream,

---
 rtl/acq_pkg.sv | 35 +++
 rtl/sample_serializer.sv | 70 +++++++
 rtl/acquire_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer.
// Contents: FSM state and mode enums, default command bytes, byte-split helpers.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_TX_HI    = 3'd4,
    ST_TX_LO    = 3'd5,
    ST_HOLDOFF  = 3'd6
  } acq_state_e;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_CONT   = 1'b1
  } acq_mode_e;

  typedef logic [7:0] byte_t;

  localparam byte_t CMD_SINGLE_DEF = 8'h41;  // 'A'
  localparam byte_t CMD_CONT_DEF   = 8'h43;  // 'C'
  localparam byte_t CMD_STOP_DEF   = 8'h53;  // 'S'

  // Samples are zero-extended to 16 bits before being split into two bytes.
  function automatic byte_t hi_byte(input logic [15:0] s);
    return s[15:8];
  endfunction

  function automatic byte_t lo_byte(input logic [15:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/sample_serializer.sv
// Splits one zero-extended sample into a high byte followed by a low byte on a
// valid/ready byte interface. tx_valid and tx_data are registered and only change
// on a handshake, a new load, or reset.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   load         1-cycle strobe: capture sample_ext and offer its high byte
//   sample_ext   sample zero-extended to 16 bits
//   tx_ready     transmitter accepts the current byte
//   tx_valid     byte on tx_data is offered
//   tx_data      byte offered to the transmitter
//   hi_accept    high byte handed off this cycle
//   lo_accept    low byte handed off this cycle (sample fully sent)
module sample_serializer
  import acq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] sample_ext,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        hi_accept,
  output logic        lo_accept
);

  logic  tx_valid_q, tx_valid_d;
  byte_t tx_data_q, tx_data_d;
  byte_t lo_q, lo_d;
  logic  phase_lo_q, phase_lo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      lo_q       <= '0;
      phase_lo_q <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      lo_q       <= lo_d;
      phase_lo_q <= phase_lo_d;
    end
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    lo_d       = lo_q;
    phase_lo_d = phase_lo_q;
    hi_accept  = tx_valid_q & tx_ready & ~phase_lo_q;
    lo_accept  = tx_valid_q & tx_ready & phase_lo_q;
    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = hi_byte(sample_ext);
      lo_d       = lo_byte(sample_ext);
      phase_lo_d = 1'b0;
    end else if (hi_accept) begin
      tx_data_d  = lo_q;
      phase_lo_d = 1'b1;
    end else if (lo_accept) begin
      tx_valid_d = 1'b0;
      phase_lo_d = 1'b0;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/acquire_sequencer.sv
// Command-driven acquisition controller: captures N_SAMPLES ADC samples into RAM
// on a UART command, then dumps the buffer over UART as high/low byte pairs.
// Continuous mode re-arms after a holdoff window; a stop command halts it.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_valid, rx_data     received command byte strobe
//   adc_valid, adc_data   ADC sample strobe
//   acquire               ADC gate, high while capturing
//   mem_we/waddr/wdata    capture RAM write port
//   mem_raddr, mem_rdata  capture RAM read port (1-cycle read latency)
//   tx_valid/data/ready   UART transmit byte handshake
//   busy                  high whenever not idle
//   done                  1-cycle pulse when a frame's last byte is accepted
//
// state      | meaning
// IDLE       | waiting for SINGLE/CONT command
// CAPTURE    | acquire high, writing samples to RAM
// RD_ISSUE   | read address presented to RAM
// RD_WAIT    | RAM data arriving, loaded into serializer
// TX_HI      | high byte offered
// TX_LO      | low byte offered
// HOLDOFF    | continuous-mode gap before the next capture
module acquire_sequencer
  import acq_pkg::*;
#(
  parameter int          N_SAMPLES      = 1024,
  parameter int          ADDR_W         = 10,
  parameter int          DATA_W         = 12,
  parameter int          HOLDOFF_CYCLES = 15040,
  parameter logic [7:0]  CMD_SINGLE     = CMD_SINGLE_DEF,
  parameter logic [7:0]  CMD_CONT       = CMD_CONT_DEF,
  parameter logic [7:0]  CMD_STOP       = CMD_STOP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              acquire,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int HO_W    = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int HO_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(N_SAMPLES);

  acq_state_e        state_q, state_d;
  acq_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [HO_W-1:0]   holdoff_cnt_q, holdoff_cnt_d;
  logic              acquire_q, acquire_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;

  logic cmd_single, cmd_cont, cmd_stop;
  logic sample_last, rd_last;
  logic ser_load, hi_accept, lo_accept;
  acq_mode_e mode_eff;

  assign cmd_single  = rx_valid && (rx_data == CMD_SINGLE);
  assign cmd_cont    = rx_valid && (rx_data == CMD_CONT);
  assign cmd_stop    = rx_valid && (rx_data == CMD_STOP);
  assign sample_last = adc_valid && (sample_cnt_q == LAST_IDX);
  assign rd_last     = (rd_idx_q == LAST_IDX);
  // A stop during the dump demotes the frame to single so it ends in IDLE.
  assign mode_eff    = cmd_stop ? MODE_SINGLE : mode_q;
  assign ser_load    = (state_q == ST_RD_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_SINGLE;
      sample_cnt_q  <= '0;
      rd_idx_q      <= '0;
      holdoff_cnt_q <= '0;
      acquire_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      mem_raddr_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      sample_cnt_q  <= sample_cnt_d;
      rd_idx_q      <= rd_idx_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      acquire_q     <= acquire_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_raddr_q   <= mem_raddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_single || cmd_cont) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cmd_stop)         state_d = ST_IDLE;
        else if (sample_last) state_d = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_TX_HI;
      ST_TX_HI: begin
        if (hi_accept) state_d = ST_TX_LO;
      end
      ST_TX_LO: begin
        if (lo_accept) begin
          if (!rd_last)                   state_d = ST_RD_ISSUE;
          else if (mode_eff == MODE_CONT) state_d = ST_HOLDOFF;
          else                            state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (cmd_stop)                  state_d = ST_IDLE;
        else if (holdoff_cnt_q == '0)  state_d = ST_CAPTURE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d        = mode_q;
    sample_cnt_d  = sample_cnt_q;
    rd_idx_d      = rd_idx_q;
    holdoff_cnt_d = holdoff_cnt_q;
    mem_we_d      = 1'b0;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_raddr_d   = mem_raddr_q;

    if (state_q == ST_IDLE) begin
      if (cmd_single)    mode_d = MODE_SINGLE;
      else if (cmd_cont) mode_d = MODE_CONT;
    end else if (cmd_stop) begin
      mode_d = MODE_SINGLE;
    end

    if (state_d == ST_CAPTURE && state_q != ST_CAPTURE) begin
      sample_cnt_d = '0;
    end else if (state_q == ST_CAPTURE && adc_valid) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = ADDR_W'(sample_cnt_q);
      mem_wdata_d = adc_data;
      if (sample_cnt_q != FULL_CNT) sample_cnt_d = sample_cnt_q + 1'b1;
    end

    if (state_q == ST_CAPTURE) begin
      rd_idx_d = '0;
    end else if (state_q == ST_TX_LO && lo_accept && !rd_last) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
    if (state_d == ST_RD_ISSUE) mem_raddr_d = ADDR_W'(rd_idx_d);

    // Down-counter loaded on entry; leaving when it reads zero gives exactly
    // HOLDOFF_CYCLES cycles in HOLDOFF (minimum one).
    if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF) begin
      holdoff_cnt_d = HO_W'(HO_LOAD);
    end else if (state_q == ST_HOLDOFF && holdoff_cnt_q != '0) begin
      holdoff_cnt_d = holdoff_cnt_q - 1'b1;
    end

    acquire_d = (state_d == ST_CAPTURE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_TX_LO) && lo_accept && rd_last;
  end

  sample_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (ser_load),
    .sample_ext (16'(mem_rdata)),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .hi_accept  (hi_accept),
    .lo_accept  (lo_accept)
  );

  assign acquire   = acquire_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_raddr = mem_raddr_q;

endmodule
